// File: rtl/pyhdl_via_evt_pkg.sv
// rtl/pyhdl_via_evt_pkg.sv - shared header layout, event kinds, FSM states for the VIA event transmitter
package pyhdl_via_evt_pkg;

    localparam int HDR_KIND_LSB = 28;
    localparam int HDR_KIND_W   = 4;
    localparam int HDR_LEN_LSB  = 20;
    localparam int HDR_LEN_W    = 8;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_SEQ_W    = 4;
    localparam int HDR_OBJ_LSB  = 0;
    localparam int HDR_OBJ_W    = 16;

    typedef enum logic [3:0] {
        KIND_COMPONENT = 4'd1,
        KIND_OBJECT    = 4'd2,
        KIND_PHASE     = 4'd3,
        KIND_USER      = 4'd15
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_TRAIL
    } tx_state_e;

    function automatic logic [31:0] pack_header(
        input logic [HDR_KIND_W-1:0] kind,
        input logic [HDR_LEN_W-1:0]  len,
        input logic [HDR_SEQ_W-1:0]  seq,
        input logic [HDR_OBJ_W-1:0]  obj_id
    );
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_KIND_LSB +: HDR_KIND_W] = kind;
        hdr[HDR_LEN_LSB  +: HDR_LEN_W]  = len;
        hdr[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
        hdr[HDR_OBJ_LSB  +: HDR_OBJ_W]  = obj_id;
        return hdr;
    endfunction

endpackage

// File: rtl/pyhdl_via_tx_outreg.sv
// rtl/pyhdl_via_tx_outreg.sv - registered valid/ready output stage (data + last)
module pyhdl_via_tx_outreg (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic        tx_last,
    output logic        free
);

    // The register may take a new word when it is empty or its word leaves this cycle.
    assign free = !tx_valid || tx_ready;

    // Output beat register; the caller only pulses load while free is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
            tx_last  <= load_last;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/pyhdl_via_evt_tx.sv
// rtl/pyhdl_via_evt_tx.sv - frames VIA event descriptors and payload into header/payload/trailer beats
module pyhdl_via_evt_tx
    import pyhdl_via_evt_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int KIND_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic [KIND_W-1:0] evt_kind,
    input  logic [15:0]       evt_obj_id,
    input  logic [7:0]        evt_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [31:0]       pl_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [31:0]       tx_data,
    output logic              tx_last,
    output logic              err_oversize,
    output logic [15:0]       pkt_count,
    output logic [7:0]        drop_count
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic [3:0]  seq;
    logic [31:0] checksum;
    logic [7:0]  remaining;
    logic [31:0] hdr_word;
    logic        out_free;
    logic        out_load;
    logic [31:0] out_data;
    logic        out_last;
    logic        evt_ok;
    logic        evt_bad;
    logic        pl_fire;
    logic        trail_fire;

    assign hdr_word = pack_header(evt_kind, evt_len, seq, evt_obj_id);

    pyhdl_via_tx_outreg u_outreg (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (out_load),
        .load_data (out_data),
        .load_last (out_last),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .free      (out_free)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshakes and output-register load selection.
    // The header is loaded on the accepting edge (the register is always empty in IDLE),
    // so HDR is the cycle the header sits on the bus while the first payload word or the
    // trailer may already be pulled in behind it.
    always_comb begin
        state_nxt  = state;
        evt_ready  = 1'b0;
        pl_ready   = 1'b0;
        evt_ok     = 1'b0;
        evt_bad    = 1'b0;
        pl_fire    = 1'b0;
        trail_fire = 1'b0;
        out_load   = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                evt_ready = 1'b1;
                evt_ok    = evt_valid && (evt_len <= MAX_LEN_B);
                evt_bad   = evt_valid && (evt_len > MAX_LEN_B);
                if (evt_ok) begin
                    out_load  = 1'b1;
                    out_data  = hdr_word;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (remaining != 8'd0) begin
                    pl_ready  = out_free;
                    pl_fire   = pl_valid && out_free;
                    out_load  = pl_fire;
                    out_data  = pl_data;
                    state_nxt = ST_PAYLOAD;
                end else if (out_free) begin
                    out_load  = 1'b1;
                    out_data  = checksum;
                    out_last  = 1'b1;
                    state_nxt = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                trail_fire = tx_valid && tx_ready;
                if (trail_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Running checksum, word countdown, sequence and statistics counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seq          <= '0;
            checksum     <= '0;
            remaining    <= '0;
            pkt_count    <= '0;
            drop_count   <= '0;
            err_oversize <= 1'b0;
        end else begin
            err_oversize <= evt_bad;
            if (evt_ok) begin
                checksum  <= hdr_word;
                remaining <= evt_len;
            end
            if (pl_fire) begin
                checksum  <= checksum ^ pl_data;
                remaining <= remaining - 8'd1;
            end
            if (trail_fire) begin
                seq       <= seq + 4'd1;
                pkt_count <= pkt_count + 16'd1;
            end
            if (evt_bad && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pyhdl_via_evt_tx.sv
// tb/tb_pyhdl_via_evt_tx.sv - directed self-checking bench for pyhdl_via_evt_tx
module tb_pyhdl_via_evt_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [3:0]  evt_kind = '0;
    logic [15:0] evt_obj_id = '0;
    logic [7:0]  evt_len = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [31:0] pl_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        err_oversize;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;

    always #5 clock = ~clock;

    pyhdl_via_evt_tx #(.MAX_LEN(64), .KIND_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_kind     (evt_kind),
        .evt_obj_id   (evt_obj_id),
        .evt_len      (evt_len),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .pl_data      (pl_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .err_oversize (err_oversize),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] pl_buf [256];
    logic [32:0] got [$];
    logic [32:0] exp_q [$];
    int          beat_cyc [$];
    logic [3:0]  r_kind;
    logic [15:0] r_obj;
    logic [7:0]  r_len;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        evt_valid = 1'b0;
        pl_valid  = 1'b0;
        tx_ready  = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic build_exp(input logic [3:0] kind, input logic [15:0] obj, input logic [7:0] len,
                             input logic [3:0] seq);
        logic [31:0] x;
        x = {kind, len, seq, obj};
        exp_q.delete();
        exp_q.push_back({1'b0, x});
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({1'b0, pl_buf[i]});
            x = x ^ pl_buf[i];
        end
        exp_q.push_back({1'b1, x});
    endtask

    task automatic cmp_pkt(input string tag);
        check_eq({tag, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic send_pkt(input logic [3:0] kind, input logic [15:0] obj, input logic [7:0] len,
                            input bit rnd, input int abort_at);
        int          pl_idx = 0;
        int          guard = 0;
        bit          acc = 0;
        bit          done = 0;
        bit          aborted = 0;
        bit          stall_prev = 0;
        logic [32:0] prev_word = '0;
        got.delete();
        beat_cyc.delete();
        evt_kind   = kind;
        evt_obj_id = obj;
        evt_len    = len;
        while (!done && guard < 5000) begin
            @(negedge clock);
            guard++;
            if (abort_at >= 0 && pl_idx == abort_at) begin
                check_eq("pre_rst_valid", 64'(tx_valid), 64'd1);
                reset_n   = 1'b0;
                evt_valid = 1'b0;
                pl_valid  = 1'b0;
                #1;
                check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
                check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);
                check_eq("rst_drop_count", 64'(drop_count), 64'd0);
                check_eq("rst_evt_ready", 64'(evt_ready), 64'd1);
                aborted = 1;
                break;
            end
            tx_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            evt_valid = !acc;
            pl_valid  = (pl_idx < int'(len)) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            pl_data   = (pl_idx < int'(len)) ? pl_buf[pl_idx] : 32'h0;
            #1;
            if (stall_prev)
                check_eq("stall_hold", 64'({tx_valid, tx_last, tx_data}), 64'({1'b1, prev_word}));
            if (evt_valid && evt_ready) begin
                acc = 1;
                acc_cyc = cyc;
            end
            if (pl_valid && pl_ready) pl_idx++;
            if (tx_valid && tx_ready) begin
                got.push_back({tx_last, tx_data});
                beat_cyc.push_back(cyc);
                if (tx_last) done = 1;
            end
            stall_prev = tx_valid && !tx_ready;
            prev_word  = {tx_last, tx_data};
        end
        evt_valid = 1'b0;
        pl_valid  = 1'b0;
        if (!done && !aborted) check_eq("pkt_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge clock);
        pl_valid = 1'b1;
        #1;
        check_eq("rst_evt_ready", 64'(evt_ready), 64'd1);
        check_eq("idle_pl_ready", 64'(pl_ready), 64'd0);
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_tx_data", 64'(tx_data), 64'd0);
        check_eq("rst_tx_last", 64'(tx_last), 64'd0);
        check_eq("rst_err", 64'(err_oversize), 64'd0);
        check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);
        check_eq("rst_drop_count", 64'(drop_count), 64'd0);
        @(negedge clock);
        pl_valid = 1'b0;
        #1;
        check_eq("idle_pl_ignored", 64'(tx_valid), 64'd0);

        // kind=2 obj=0x1234 len=2, free-flowing bridge
        pl_buf[0] = 32'hAAAA0000;
        pl_buf[1] = 32'h0000BBBB;
        exp_q = '{33'h0_20201234, 33'h0_AAAA0000, 33'h0_0000BBBB, 33'h1_8A8AA98F};
        send_pkt(4'd2, 16'h1234, 8'd2, 0, -1);
        cmp_pkt("pktA");
        if (got.size() == 4) begin
            check_eq("hdr_latency", 64'(beat_cyc[0] - acc_cyc), 64'd1);
            check_eq("beats_consec", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
        end
        @(negedge clock);
        check_eq("pktA_count", 64'(pkt_count), 64'd1);

        // next header carries seq=1
        exp_q = '{33'h0_10010001, 33'h1_10010001};
        send_pkt(4'd1, 16'h0001, 8'd0, 0, -1);
        cmp_pkt("seq1_len0");

        // len=0 from a fresh reset
        do_reset();
        exp_q = '{33'h0_10000001, 33'h1_10000001};
        send_pkt(4'd1, 16'h0001, 8'd0, 0, -1);
        cmp_pkt("len0");
        if (got.size() == 2) check_eq("len0_consec", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);

        // oversize descriptor
        @(negedge clock);
        evt_valid = 1'b1;
        evt_len   = 8'd65;
        tx_ready  = 1'b1;
        #1;
        check_eq("ovs_evt_ready", 64'(evt_ready), 64'd1);
        @(negedge clock);
        evt_valid = 1'b0;
        #1;
        check_eq("ovs_err_pulse", 64'(err_oversize), 64'd1);
        check_eq("ovs_no_tx", 64'(tx_valid), 64'd0);
        @(negedge clock);
        #1;
        check_eq("ovs_err_clear", 64'(err_oversize), 64'd0);
        check_eq("ovs_no_tx2", 64'(tx_valid), 64'd0);
        check_eq("ovs_drop1", 64'(drop_count), 64'd1);

        pl_buf[0] = 32'h12345678;
        exp_q = '{33'h0_3011BEEF, 33'h0_12345678, 33'h1_2225E897};
        send_pkt(4'd3, 16'hBEEF, 8'd1, 0, -1);
        cmp_pkt("after_ovs");

        // 300 further rejections saturate the drop counter
        @(negedge clock);
        evt_len   = 8'd200;
        evt_valid = 1'b1;
        repeat (300) @(negedge clock);
        evt_valid = 1'b0;
        #1;
        check_eq("drop_sat_tx", 64'(tx_valid), 64'd0);
        @(negedge clock);
        #1;
        check_eq("drop_sat", 64'(drop_count), 64'd255);
        check_eq("drop_pkt_count", 64'(pkt_count), 64'd2);

        // 100 packets under random backpressure and payload bubbles
        do_reset();
        for (int i = 0; i < 100; i++) begin
            r_kind = 4'($urandom);
            r_obj  = 16'($urandom);
            r_len  = (i % 25 == 0) ? 8'd64 : 8'($urandom_range(0, 6));
            for (int j = 0; j < int'(r_len); j++) pl_buf[j] = $urandom;
            build_exp(r_kind, r_obj, r_len, 4'(i % 16));
            send_pkt(r_kind, r_obj, r_len, 1, -1);
            cmp_pkt($sformatf("rnd%0d", i));
        end
        @(negedge clock);
        check_eq("rnd_pkt_count", 64'(pkt_count), 64'd100);

        // 17 back-to-back packets: seq wraps 15 -> 0
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pl_buf[0] = 32'(i);
            build_exp(4'd15, 16'(i), 8'd1, 4'(i % 16));
            send_pkt(4'd15, 16'(i), 8'd1, 0, -1);
            cmp_pkt($sformatf("b2b%0d", i));
        end
        @(negedge clock);
        check_eq("b2b_pkt_count", 64'(pkt_count), 64'd17);

        // reset during payload word 3 of 8, then a clean packet with seq=0
        for (int j = 0; j < 8; j++) pl_buf[j] = 32'hC0DE0000 + 32'(j);
        send_pkt(4'd5, 16'h5555, 8'd8, 0, 3);
        do_reset();
        pl_buf[0] = 32'h00000001;
        exp_q = '{33'h0_401000AA, 33'h0_00000001, 33'h1_401000AB};
        send_pkt(4'd4, 16'h00AA, 8'd1, 0, -1);
        cmp_pkt("post_rst");
        @(negedge clock);
        check_eq("post_rst_count", 64'(pkt_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pyhdl_via_evt_tx.md
Name: pyhdl_via_evt_tx

Overview:
- HDL-side transmitter for VIA event packets travelling from the simulator toward the Python root listener.
- The listener path delivers Python-originated notifications into HDL; this block carries component/object events the other way.
- Accepts an event descriptor plus a payload word stream, frames them as header / payload / checksum-trailer, and drives a registered valid/ready word stream into the pyhdl-if bridge.
- Sits between HDL component models and the bridge endpoint.

Parameters:
- MAX_LEN, 64: largest payload word count accepted; range 0..255.
- KIND_W, 4: event kind field width; fixed by header format.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- evt_valid  in  1  descriptor valid.
- evt_ready  out  1  descriptor accepted when valid&ready.
- evt_kind  in  4  event kind (component/object/phase...).
- evt_obj_id  in  16  source object handle.
- evt_len  in  8  payload word count.
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  payload word accepted.
- pl_data  in  32  payload word.
- tx_valid  out  1  output word valid.
- tx_ready  in  1  bridge accepts word.
- tx_data  out  32  output word.
- tx_last  out  1  marks trailer word.
- err_oversize  out  1  one-cycle pulse when descriptor rejected.
- pkt_count  out  16  packets fully sent; wraps.
- drop_count  out  8  rejected descriptors; saturates at 255.

Behaviour:
- Reset (async assert, sync release): state IDLE; evt_ready=1; pl_ready=0; tx_valid=0; tx_data=0; tx_last=0; err_oversize=0; seq=0; checksum=0; pkt_count=0; drop_count=0.
- Header word: [31:28] kind, [27:20] len, [19:16] seq[3:0], [15:0] obj_id.
- Trailer word: XOR of header and all payload words.
- seq is a 4-bit counter. It increments when a trailer is accepted and wraps 15->0.
- Output register rule: tx_data, tx_valid and tx_last hold stable while tx_valid&!tx_ready. The register loads only when !tx_valid || tx_ready. No combinational path from tx_ready to tx_data.
- FSM states: IDLE, HDR, PAYLOAD, TRAIL.
- IDLE: evt_ready=1.
  - evt handshake with evt_len<=MAX_LEN: latch descriptor, go to HDR.
  - evt handshake with evt_len>MAX_LEN: stay in IDLE, pulse err_oversize next cycle, increment drop_count (saturating), send nothing.
- HDR: load header into the output register when free; checksum=header; remaining=len.
  - If len==0, go to TRAIL; otherwise go to PAYLOAD.
  - evt_ready=0 from HDR until trailer acceptance.
- PAYLOAD: pl_ready = output register free (!tx_valid || tx_ready).
  - On pl handshake: load pl_data, checksum^=pl_data, remaining-1.
  - After the last word, go to TRAIL.
  - Payload bubbles (pl_valid=0) are legal and stall only.
- TRAIL: load checksum with tx_last=1. On trailer acceptance: pkt_count+1 (wrapping), seq+1, go to IDLE; evt_ready reasserts the next cycle.
- Latency:
  - Descriptor accepted at cycle N -> header tx_valid at N+1.
  - Payload word accepted at cycle M -> on tx_data at M+1.
  - With tx_ready held high, a len=L packet occupies L+2 consecutive tx beats (1-cycle gap after IDLE acceptance).
- Simultaneous events:
  - pl_valid outside PAYLOAD is ignored (pl_ready=0).
  - evt_valid during an active packet is held off by evt_ready=0.
- Reset mid-packet: the partial packet is discarded with no trailer. Counters and seq clear; the bridge side must tolerate a truncated frame after reset.
- tx_ready low indefinitely: the block stalls with no loss and no timeout.

Decomposition:
- Shared package pyhdl_via_evt_pkg holds:
  - Header field offsets/widths.
  - Event kind enum: KIND_COMPONENT=1, KIND_OBJECT=2, KIND_PHASE=3, KIND_USER=15.
  - FSM state typedef.
  - Header pack function.
- One sub-module, pyhdl_via_tx_outreg: the registered valid/ready output stage (data+last). The FSM drives its load strobe.

Test Plan:
- kind=2, obj_id=0x1234, len=2, payload 0xAAAA0000,0x0000BBBB, tx_ready=1 -> tx words 0x20201234, 0xAAAA0000, 0x0000BBBB, trailer=XOR (tx_last=1); pkt_count=1; seq of next header=1.
- len=0, kind=1, obj_id=0x0001 -> header 0x10000001 then trailer 0x10000001 with tx_last; exactly 2 beats.
- len=65 with MAX_LEN=64 -> no tx_valid; err_oversize single-cycle pulse; drop_count=1; next legal event sends normally. 300 rejections -> drop_count=255.
- Random tx_ready backpressure (50%) and pl_valid bubbles over 100 packets -> tx_data stable while stalled; every packet checksum-correct; pkt_count=100.
- 17 back-to-back packets -> header seq field runs 0..15,0; pkt_count=17.
- reset_n asserted mid-payload (word 3 of 8) -> tx_valid=0 immediately; counters=0; following packet header seq=0 and sends correctly.
